// File: rtl/rotate_2d_pkg.sv
`default_nettype none
// ============================================================================
// rotate_pkg : shared states, angle constants and degree wrap helper
// Rev 1.0
// ============================================================================
package rotate_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOK_SIN = 3'd1,
        LOOK_COS = 3'd2,
        MULT     = 3'd3,
        SUM      = 3'd4,
        OUT      = 3'd5
    } state_t;

    localparam int ANGLE_W = 9;
    localparam logic [ANGLE_W:0] DEG_90  = 10'd90;
    localparam logic [ANGLE_W:0] DEG_360 = 10'd360;

    // Single conditional subtract; inputs never reach 720 so one pass suffices.
    function automatic logic [ANGLE_W-1:0] wrap_deg(input logic [ANGLE_W:0] deg);
        logic [ANGLE_W:0] w_red;
        w_red = (deg >= DEG_360) ? (deg - DEG_360) : deg;
        return w_red[ANGLE_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rotate_2d_if.sv
`default_nettype none
// ============================================================================
// rotate_2d_if : point handshakes plus the sine table angle/data link
// Rev 1.0
// ============================================================================
interface rotate_2d_if
    import rotate_pkg::*;
#(
    parameter int COORD_W = 12
);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [COORD_W-1:0] in_x;
    logic signed [COORD_W-1:0] in_y;
    logic        [ANGLE_W-1:0] in_angle;
    logic        [ANGLE_W-1:0] tbl_id;
    logic signed [15:0]        tbl_data;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [COORD_W-1:0] out_x;
    logic signed [COORD_W-1:0] out_y;

    modport slave (
        input  in_valid, in_x, in_y, in_angle, tbl_data, out_ready,
        output in_ready, tbl_id, out_valid, out_x, out_y
    );

    modport master (
        output in_valid, in_x, in_y, in_angle, tbl_data, out_ready,
        input  in_ready, tbl_id, out_valid, out_x, out_y
    );
endinterface
`default_nettype wire

// File: rtl/rotate_2d_round_sat_shift.sv
`default_nettype none
// ============================================================================
// round_sat_shift : add half LSB, arithmetic shift right, saturate to OUT_W
// Rev 1.0
// ============================================================================
module round_sat_shift #(
    parameter int IN_W  = 29,
    parameter int SHIFT = 8,
    parameter int OUT_W = 12
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);
    localparam logic signed [IN_W-1:0] c_half = IN_W'(64'sd1 <<< (SHIFT - 1));
    localparam logic signed [IN_W-1:0] c_max  = IN_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [IN_W-1:0] c_min  = IN_W'(-(64'sd1 <<< (OUT_W - 1)));

    logic signed [IN_W-1:0] w_rounded;
    logic signed [IN_W-1:0] w_shifted;

    // Caller guarantees one bit of headroom so the half-LSB add cannot wrap.
    assign w_rounded = din + c_half;
    assign w_shifted = w_rounded >>> SHIFT;

    always_comb begin
        dout = w_shifted[OUT_W-1:0];
        if (w_shifted > c_max) begin
            dout = c_max[OUT_W-1:0];
        end else if (w_shifted < c_min) begin
            dout = c_min[OUT_W-1:0];
        end
    end
endmodule
`default_nettype wire

// File: rtl/rotate_2d.sv
`default_nettype none
// ============================================================================
// rotate_2d : rotate a signed point by an integer angle using two sine lookups
// Rev 1.0
// ============================================================================
module rotate_2d
    import rotate_pkg::*;
#(
    parameter int COORD_W = 12,
    parameter int TBL_LAT = 2,
    parameter int Q_FRAC  = 8
) (
    input  logic        clk,
    input  logic        rst,
    rotate_2d_if.slave  bus
);
    localparam int c_tbl_w  = 16;
    localparam int c_prod_w = COORD_W + c_tbl_w;
    localparam int c_sum_w  = c_prod_w + 1;
    localparam int c_cnt_w  = $clog2(TBL_LAT + 2);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(TBL_LAT);

    state_t r_state;
    state_t w_state_next;

    logic        [c_cnt_w-1:0]  r_cnt;
    logic signed [COORD_W-1:0]  r_x;
    logic signed [COORD_W-1:0]  r_y;
    logic        [ANGLE_W-1:0]  r_angle;
    logic        [ANGLE_W-1:0]  r_tbl_id;
    logic signed [c_tbl_w-1:0]  r_s;
    logic signed [c_tbl_w-1:0]  r_c;
    logic signed [c_prod_w-1:0] r_p_xc;
    logic signed [c_prod_w-1:0] r_p_ys;
    logic signed [c_prod_w-1:0] r_p_xs;
    logic signed [c_prod_w-1:0] r_p_yc;
    logic                       r_out_valid;
    logic signed [COORD_W-1:0]  r_out_x;
    logic signed [COORD_W-1:0]  r_out_y;

    logic                       w_cnt_done;
    logic        [ANGLE_W-1:0]  w_in_angle_red;
    logic        [ANGLE_W-1:0]  w_cos_angle;
    logic signed [c_prod_w-1:0] w_x_ext;
    logic signed [c_prod_w-1:0] w_y_ext;
    logic signed [c_prod_w-1:0] w_s_ext;
    logic signed [c_prod_w-1:0] w_c_ext;
    logic signed [c_sum_w-1:0]  w_rx;
    logic signed [c_sum_w-1:0]  w_ry;
    logic signed [COORD_W-1:0]  w_rx_sat;
    logic signed [COORD_W-1:0]  w_ry_sat;

    assign w_cnt_done     = (r_cnt == '0);
    assign w_in_angle_red = wrap_deg({1'b0, bus.in_angle});
    assign w_cos_angle    = wrap_deg({1'b0, r_angle} + DEG_90);

    // Operands widened first so each product is a plain same-width signed multiply.
    assign w_x_ext = c_prod_w'(r_x);
    assign w_y_ext = c_prod_w'(r_y);
    assign w_s_ext = c_prod_w'(r_s);
    assign w_c_ext = c_prod_w'(r_c);

    assign w_rx = c_sum_w'(r_p_xc) - c_sum_w'(r_p_ys);
    assign w_ry = c_sum_w'(r_p_xs) + c_sum_w'(r_p_yc);

    round_sat_shift #(
        .IN_W  (c_sum_w),
        .SHIFT (Q_FRAC),
        .OUT_W (COORD_W)
    ) u_rss_x (
        .din  (w_rx),
        .dout (w_rx_sat)
    );

    round_sat_shift #(
        .IN_W  (c_sum_w),
        .SHIFT (Q_FRAC),
        .OUT_W (COORD_W)
    ) u_rss_y (
        .din  (w_ry),
        .dout (w_ry_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (bus.in_valid) w_state_next = LOOK_SIN;
            LOOK_SIN: if (w_cnt_done)   w_state_next = LOOK_COS;
            LOOK_COS: if (w_cnt_done)   w_state_next = MULT;
            MULT:                       w_state_next = SUM;
            SUM:                        w_state_next = OUT;
            OUT:      if (bus.out_ready) w_state_next = IDLE;
            default:                    w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_angle     <= '0;
            r_tbl_id    <= '0;
            r_s         <= '0;
            r_c         <= '0;
            r_p_xc      <= '0;
            r_p_ys      <= '0;
            r_p_xs      <= '0;
            r_p_yc      <= '0;
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_x      <= bus.in_x;
                        r_y      <= bus.in_y;
                        r_angle  <= w_in_angle_red;
                        r_tbl_id <= w_in_angle_red;
                        r_cnt    <= c_cnt_load;
                    end
                end
                LOOK_SIN: begin
                    if (w_cnt_done) begin
                        r_s      <= bus.tbl_data;
                        r_tbl_id <= w_cos_angle;
                        r_cnt    <= c_cnt_load;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                LOOK_COS: begin
                    if (w_cnt_done) begin
                        r_c <= bus.tbl_data;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                MULT: begin
                    r_p_xc <= w_x_ext * w_c_ext;
                    r_p_ys <= w_y_ext * w_s_ext;
                    r_p_xs <= w_x_ext * w_s_ext;
                    r_p_yc <= w_y_ext * w_c_ext;
                end
                SUM: begin
                    r_out_x     <= w_rx_sat;
                    r_out_y     <= w_ry_sat;
                    r_out_valid <= 1'b1;
                end
                OUT: begin
                    if (bus.out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE) && !rst;
    assign bus.tbl_id    = r_tbl_id;
    assign bus.out_valid = r_out_valid;
    assign bus.out_x     = r_out_x;
    assign bus.out_y     = r_out_y;
endmodule
`default_nettype wire

// File: doc/rotate_2d.md
# rotate_2d

Rotates a signed 2-D point about the origin by an integer angle in degrees, using the shared sine lookup table as its trig source. It sits directly downstream of `sine_table`. It drives the table's angle input, captures sin θ and cos θ as two sequential lookups (cos θ = sin(θ+90°)), then produces the rotated point through a multiply/round/saturate pipeline. Valid/ready handshakes sit on both sides, and it processes one point at a time.

## Interface
- `COORD_W`, default 12: signed coordinate width, in and out.
- `TBL_LAT`, default 2: cycles from a stable `tbl_id` to valid `tbl_data`.
- `Q_FRAC`, default 8: fractional bits of table data (256 = 1.0).
- `clk`, in, 1: single clock, all logic on posedge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: input point and angle valid.
- `in_ready`, out, 1: block can accept; equals `(state==IDLE) && !rst`.
- `in_x`, `in_y`, in, COORD_W: signed input point.
- `in_angle`, in, 9: degrees, 0..511 accepted.
- `tbl_id`, out, 9: angle to the sine table, registered, always 0..359.
- `tbl_data`, in, 16: signed table output, value round(256·sin(id°)) saturated to ±255.
- `out_valid`, out, 1: rotated point valid.
- `out_ready`, in, 1: downstream accepts.
- `out_x`, `out_y`, out, COORD_W: signed rotated point.

## Operation
- **Reset values.** State is IDLE. `out_valid`=0, `out_x`=`out_y`=0, `tbl_id`=0. All internal registers are 0.
- **IDLE.** On `in_valid && in_ready`, latch x, y and the angle.
  - The angle is reduced once: if ≥360, subtract 360.
  - Load `tbl_id` with the reduced angle and go to LOOK_SIN.
- **LOOK_SIN.** Hold `tbl_id` for TBL_LAT+1 cycles, counted by a down-counter.
  - On the last cycle, capture `tbl_data` as s.
  - Load `tbl_id` with angle+90, minus 360 if the sum is ≥360. Go to LOOK_COS.
- **LOOK_COS.** Same as LOOK_SIN; capture `tbl_data` as c, then go to MULT.
- **MULT.** Register four signed products: x·c, y·s, x·s and y·c, each COORD_W+16 bits.
- **SUM.** Compute two sums at full width:
  - rx = x·c − y·s + 2^(Q_FRAC−1)
  - ry = x·s + y·c + 2^(Q_FRAC−1)
  - Arithmetic-shift each right by Q_FRAC, then saturate to [−2^(COORD_W−1), 2^(COORD_W−1)−1].
  - Register the results into `out_x`/`out_y`, set `out_valid`=1 and go to OUT.
- **OUT.** Hold the outputs stable while `out_ready`=0.
  - On `out_ready`, clear `out_valid` and go to IDLE.
  - `out_x`/`out_y` keep their last values after the transfer.
- **No overlap.** `in_ready`=0 in every state except IDLE.
- **Reset mid-operation.** Any state returns immediately to IDLE with reset values. A partially processed point is discarded and no output is produced.

## Timing
- Acceptance edge is E0.
- `tbl_id` = θ from E0. s is captured at edge E0+TBL_LAT+1.
- `tbl_id` = θ+90 from that edge. c is captured at E0+2·(TBL_LAT+1).
- MULT registers at the next edge, and SUM registers (`out_valid`↑) at the edge after that.
- Latency from acceptance to `out_valid` is 2·TBL_LAT+4 edges (8 with defaults).
- An output transfer on edge Eo makes the block IDLE from Eo, so `in_ready`=1 in the cycle after Eo. There is no same-cycle bypass.
- Best throughput is one point per 2·TBL_LAT+6 cycles.
- `tbl_id` changes only on state-transition edges and is stable for TBL_LAT+1 cycles before each capture.

## Structure
- Package `rotate_pkg`:
  - state enum {IDLE, LOOK_SIN, LOOK_COS, MULT, SUM, OUT}
  - `ANGLE_W`=9, `DEG_90`=90, `DEG_360`=360
  - function `wrap_deg` (single conditional subtract of 360)
- Sub-module `round_sat_shift`: parameterised on input width, shift and output width. Adds the half-LSB, arithmetic-shifts and saturates. It is instantiated twice (x and y).
- Top level holds the FSM, latency counter, operand registers and product registers.

## Test plan
- **Angle 0.** Point (100,0), table model with TBL_LAT=2 → s=0, c=255. `out_x`=100, `out_y`=0, with `out_valid` exactly 8 edges after acceptance.
- **Angle 90.** Point (100,0) → `out_x`=0, `out_y`=100. `tbl_id` sequence is 90 then 180.
- **Angle 30.** Point (100,0), s=128, c=222 → (87, 50). **Angle 180**, same point → (−100, 0), confirming floor rounding of negatives.
- **Angle wrap.** Angle 450 → identical result to 90. Angle 300 → cos lookup `tbl_id`=30.
- **Saturation.** Point (2047,2047) at angle 45, s=c=181 → `out_x`=0, `out_y`=2047 (saturated).
- **Backpressure and reset.**
  - Hold `out_ready`=0 for 5 cycles: outputs stay stable and `in_ready`=0.
  - Assert `rst` during LOOK_COS: `out_valid` stays 0, `tbl_id`=0, and `in_ready`=1 after release.
